mem_arbiter_rr: RTL

//  N-channel memory arbiter: successor to the 2-port inst/data memory front end. Sits between the
//  CPU fetch/LSU/DMA ports and one single-port memory (cmd_start/cmd_ready/rdata_valid protocol).

---
 rtl/mem_arbiter_rr_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_if.sv | 28 ++
 rtl/mem_arbiter_rr_rr_arbiter.sv | 43 ++++
 rtl/mem_arbiter_rr.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_rr_pkg.sv
// rtl/mem_arbiter_rr_pkg.sv - shared encodings and helpers for the memory arbiter
package mem_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_READ = 2'd2
  } state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Idle value driven onto the memory command fields (sliced to width)
  localparam logic [63:0] ADDR_NOP = '1;

  // Index width that stays legal for a single channel
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// rtl/mem_arbiter_rr_if.sv - request/response bus, N lanes packed side by side
interface mem_arbiter_rr_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic [N-1:0]        start;
  logic [N-1:0]        write;
  logic [N-1:0]        ready;
  logic [N*ADDR_W-1:0] addr;
  logic [N*DATA_W-1:0] wdata;
  logic [N*MASK_W-1:0] wmask;
  logic [N*DATA_W-1:0] rdata;
  logic [N-1:0]        rdata_valid;

  modport master (
    output start, write, addr, wdata, wmask,
    input  ready, rdata, rdata_valid
  );

  modport slave (
    input  start, write, addr, wdata, wmask,
    output ready, rdata, rdata_valid
  );

endinterface

// File: rtl/mem_arbiter_rr_rr_arbiter.sv
// rtl/mem_arbiter_rr_rr_arbiter.sv - round-robin / fixed-priority request picker
module rr_arbiter
  import mem_arbiter_rr_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int ARB_MODE = ARB_RR,
  localparam int IW      = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [N_CH-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  // Pick the first requester at/after ptr (RR) or the lowest requester (fixed)
  always_comb begin : arb_pick
    logic found;
    int   j;
    found   = 1'b0;
    j       = 0;
    idx_o   = '0;
    grant_o = '0;
    any_o   = |req_i;
    if (ARB_MODE == ARB_FIXED) begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (req_i[k]) idx_o = IW'(k);
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        j = (int'(ptr_i) + k) % N_CH;
        if (!found && req_i[j]) begin
          idx_o = IW'(j);
          found = 1'b1;
        end
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      grant_o[k] = any_o && (idx_o == IW'(k));
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-channel buffered arbiter in front of a single-port memory
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_RR,
  localparam int MASK_W  = DATA_W / 8,
  localparam int IW      = idx_w(N_CH)
) (
  input logic             clk_i,
  input logic             reset_i,
  input logic             halt_i,
  mem_arbiter_rr_if.slave  ch_if,
  mem_arbiter_rr_if.master mem_if
);

  state_e              state_q, state_d;
  logic [IW-1:0]       g_q, g_d;
  logic [N_CH-1:0]     g_oh_q, g_oh_d;
  logic [IW-1:0]       ptr_q, ptr_d;

  logic [N_CH-1:0]     buf_valid_q;
  logic [N_CH-1:0]     buf_write_q;
  logic [ADDR_W-1:0]   buf_addr_q  [N_CH];
  logic [DATA_W-1:0]   buf_wdata_q [N_CH];
  logic [MASK_W-1:0]   buf_wmask_q [N_CH];

  logic [N_CH*DATA_W-1:0] rdata_q;
  logic [N_CH-1:0]        rvalid_q;

  logic [N_CH-1:0]     ch_ready;
  logic [N_CH-1:0]     capture;
  logic [N_CH-1:0]     arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic                write_done;
  logic                read_done;
  logic                buf_clr;

  rr_arbiter #(
    .N_CH     (N_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req_i   (buf_valid_q),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign ch_ready   = ~buf_valid_q & {N_CH{~halt_i}};
  assign capture    = ch_if.start & ch_ready;
  // A write retires when memory accepts it; halt blocks acceptance
  assign write_done = (state_q == ST_ISSUE) && !halt_i && mem_if.ready[0] && buf_write_q[g_q];
  // A read already in flight completes even while halted so data is not lost
  assign read_done  = (state_q == ST_WAIT_READ) && mem_if.rdata_valid[0];
  assign buf_clr    = write_done || read_done;

  // FSM state, latched grant and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      g_oh_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      g_oh_q  <= g_oh_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: grant in IDLE, hold command until accepted, wait for read data
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    g_oh_d  = g_oh_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (!halt_i && arb_any) begin
          state_d = ST_ISSUE;
          g_d     = arb_idx;
          g_oh_d  = arb_grant;
          ptr_d   = (arb_idx == IW'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      ST_ISSUE: begin
        if (!halt_i && mem_if.ready[0]) begin
          state_d = buf_write_q[g_q] ? ST_IDLE : ST_WAIT_READ;
        end
      end
      ST_WAIT_READ: begin
        if (mem_if.rdata_valid[0]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: memory command only while issuing, channel status from buffers
  always_comb begin
    mem_if.start    = '0;
    mem_if.write    = '0;
    mem_if.addr     = ADDR_NOP[ADDR_W-1:0];
    mem_if.wdata    = '1;
    mem_if.wmask    = '1;
    if (state_q == ST_ISSUE) begin
      mem_if.start[0] = !halt_i;
      mem_if.write[0] = buf_write_q[g_q];
      mem_if.addr     = buf_addr_q[g_q];
      mem_if.wdata    = buf_wdata_q[g_q];
      mem_if.wmask    = buf_wmask_q[g_q];
    end
    ch_if.ready       = ch_ready;
    ch_if.rdata       = rdata_q;
    ch_if.rdata_valid = rvalid_q;
  end

  // One-entry request buffer per channel; a retiring slot can be refilled later
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_valid_q <= '0;
      buf_write_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        buf_addr_q[i]  <= '0;
        buf_wdata_q[i] <= '0;
        buf_wmask_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (buf_clr && g_oh_q[i]) begin
          buf_valid_q[i] <= 1'b0;
        end else if (capture[i]) begin
          buf_valid_q[i] <= 1'b1;
          buf_write_q[i] <= ch_if.write[i];
          buf_addr_q[i]  <= ch_if.addr[i*ADDR_W +: ADDR_W];
          buf_wdata_q[i] <= ch_if.wdata[i*DATA_W +: DATA_W];
          buf_wmask_q[i] <= ch_if.wmask[i*MASK_W +: MASK_W];
        end
      end
    end
  end

  // Return read data to the granted channel with a one-cycle valid pulse
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q  <= '1;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= '0;
      if (read_done) begin
        rdata_q[int'(g_q)*DATA_W +: DATA_W] <= mem_if.rdata[DATA_W-1:0];
        rvalid_q <= g_oh_q;
      end
    end
  end

endmodule
